// File: rtl/usb_fs_pkg.sv
// Shared definitions for the full-speed USB transmit path:
// PIDs, CRC16 constants, line encodings and FSM states.
package usb_fs_pkg;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Encoded as {dp, dn}
    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP
    } tx_state_t;

    function automatic logic [15:0] reverse16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    function automatic line_t line_toggle(input line_t l);
        return (l == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_fs_crc16.sv
// Serial CRC16 in reflected form: one bit per enable, LSB-first
// order, so the register holds the bit-reversed conventional CRC.
module usb_fs_crc16
    import usb_fs_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    localparam logic [15:0] POLY_REFL = reverse16(CRC16_POLY);

    logic        fb;
    logic [15:0] crc_n;

    always_comb begin
        fb    = crc_out[0] ^ bit_in;
        crc_n = {1'b0, crc_out[15:1]} ^ (fb ? POLY_REFL : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            crc_out <= CRC16_INIT;
        end else if (enable) begin
            crc_out <= crc_n;
        end
    end

endmodule

// File: rtl/usb_fs_tx_engine.sv
// Full-speed USB packet transmitter: SYNC, PID, optional DATA+CRC16,
// EOP; LSB-first, bit-stuffed and NRZI-encoded on the D+/D- pads.
module usb_fs_tx_engine
    import usb_fs_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       tx_pkt_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_data_avail,
    input  logic [7:0] tx_data,
    output logic       tx_data_get,
    output logic       usb_oe,
    output logic       usb_dp,
    output logic       usb_dn,
    output logic       pkt_end
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

    tx_state_t   state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]  bit_idx, idx_n;
    logic [7:0]  shift, shift_n;
    logic        crc_hi, crc_hi_n;
    logic [2:0]  stuff_cnt, cnt_n;
    logic        stuffing, stuffing_n;
    line_t       line, line_n;
    logic        oe, oe_n;
    logic        end_q, end_n;
    logic [3:0]  pid, pid_n;

    logic        tick;
    logic        cur_raw;
    logic [2:0]  ones;
    logic        do_stuff;
    logic        data_pid;
    logic        new_bit;
    logic        raw_n;
    logic [3:0]  crc_pos;
    logic        crc_clr;
    logic        crc_en;
    logic [15:0] crc_out;

    usb_fs_crc16 u_crc (
        .clk     (clk_48mhz),
        .reset_n (reset_n),
        .clear   (crc_clr),
        .enable  (crc_en),
        .bit_in  (shift[0]),
        .crc_out (crc_out)
    );

    always_comb begin
        tick     = (timer == TMAX);
        data_pid = (pid[1:0] == 2'b11);
        cur_raw  = stuffing ? 1'b0
                 : (state == ST_CRC) ? ~crc_out[{crc_hi, bit_idx}]
                 : shift[0];
        ones     = cur_raw ? stuff_cnt + 3'd1 : 3'd0;
        do_stuff = tick && !stuffing && (ones == 3'd6)
                 && (state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC});
        crc_clr  = (state == ST_IDLE) && tx_pkt_start;
        // Each data bit feeds the CRC once, on the first clock of its period
        crc_en   = (state == ST_DATA) && !stuffing && (timer == '0);
        tx_data_get = reset_n && tick && !do_stuff && tx_data_avail
                    && (bit_idx == 3'd7)
                    && ((state == ST_PID && data_pid) || state == ST_DATA);
    end

    always_comb begin
        state_n    = state;
        timer_n    = (state == ST_IDLE || tick) ? '0 : timer + TW'(1);
        idx_n      = bit_idx;
        shift_n    = shift;
        crc_hi_n   = crc_hi;
        cnt_n      = stuff_cnt;
        stuffing_n = stuffing;
        line_n     = line;
        oe_n       = oe;
        end_n      = 1'b0;
        pid_n      = pid;
        new_bit    = 1'b0;
        raw_n      = 1'b1;
        crc_pos    = {crc_hi, bit_idx} + 4'd1;
        case (state)
            ST_IDLE: begin
                line_n = LINE_J;
                if (tx_pkt_start) begin
                    state_n    = ST_SYNC;
                    pid_n      = tx_pid;
                    shift_n    = SYNC_BYTE;
                    idx_n      = '0;
                    crc_hi_n   = 1'b0;
                    cnt_n      = '0;
                    stuffing_n = 1'b0;
                    oe_n       = 1'b1;
                    new_bit    = 1'b1;
                    raw_n      = SYNC_BYTE[0];
                end
            end
            ST_EOP: begin
                if (tick) begin
                    if (bit_idx == 3'd2) begin
                        state_n = ST_IDLE;
                        oe_n    = 1'b0;
                        end_n   = 1'b1;
                        line_n  = LINE_J;
                    end else begin
                        idx_n  = bit_idx + 3'd1;
                        line_n = (bit_idx == 3'd1) ? LINE_J : LINE_SE0;
                    end
                end
            end
            default: begin
                if (tick) begin
                    cnt_n   = do_stuff ? 3'd0 : ones;
                    new_bit = 1'b1;
                    if (do_stuff) begin
                        // Shifter and CRC hold while the stuffed 0 is on the wire
                        stuffing_n = 1'b1;
                        raw_n      = 1'b0;
                    end else begin
                        stuffing_n = 1'b0;
                        if (state == ST_CRC) begin
                            if ({crc_hi, bit_idx} == 4'hF) begin
                                state_n = ST_EOP;
                                idx_n   = '0;
                                new_bit = 1'b0;
                                line_n  = LINE_SE0;
                            end else begin
                                {crc_hi_n, idx_n} = crc_pos;
                                raw_n = ~crc_out[crc_pos];
                            end
                        end else if (bit_idx != 3'd7) begin
                            shift_n = {1'b0, shift[7:1]};
                            idx_n   = bit_idx + 3'd1;
                            raw_n   = shift[1];
                        end else if (state == ST_SYNC) begin
                            state_n = ST_PID;
                            shift_n = {~pid, pid};
                            idx_n   = '0;
                            raw_n   = pid[0];
                        end else if (!data_pid) begin
                            state_n = ST_EOP;
                            idx_n   = '0;
                            new_bit = 1'b0;
                            line_n  = LINE_SE0;
                        end else if (tx_data_avail) begin
                            state_n = ST_DATA;
                            shift_n = tx_data;
                            idx_n   = '0;
                            raw_n   = tx_data[0];
                        end else begin
                            state_n  = ST_CRC;
                            crc_hi_n = 1'b0;
                            idx_n    = '0;
                            raw_n    = ~crc_out[0];
                        end
                    end
                end
            end
        endcase
        if (new_bit) line_n = raw_n ? line : line_toggle(line);
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            crc_hi    <= 1'b0;
            stuff_cnt <= '0;
            stuffing  <= 1'b0;
            line      <= LINE_J;
            oe        <= 1'b0;
            end_q     <= 1'b0;
            pid       <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            bit_idx   <= idx_n;
            shift     <= shift_n;
            crc_hi    <= crc_hi_n;
            stuff_cnt <= cnt_n;
            stuffing  <= stuffing_n;
            line      <= line_n;
            oe        <= oe_n;
            end_q     <= end_n;
            pid       <= pid_n;
        end
    end

    assign usb_oe           = oe;
    assign {usb_dp, usb_dn} = line;
    assign pkt_end          = end_q;

endmodule
